// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: opcodes, beat states and
// instruction field positions.
package control_sequencer_pkg;

    localparam int ADDR_LSB = 0;
    localparam int FUNC_LSB = 10;

    localparam logic [5:0] INST_CMP = 6'b000101;
    localparam logic [5:0] INST_JMP = 6'b001101;
    localparam logic [5:0] INST_STA = 6'b010100;
    localparam logic [5:0] INST_HLT = 6'b111111;

    // Beat encoding: bit0 = write half (IN), bit1 = ACTION, bit2 = second pair.
    typedef enum logic [3:0] {
        S1_OUT = 4'd0,
        S1_IN  = 4'd1,
        A1_OUT = 4'd2,
        A1_IN  = 4'd3,
        S2_OUT = 4'd4,
        S2_IN  = 4'd5,
        A2_OUT = 4'd6,
        A2_IN  = 4'd7,
        HALT   = 4'd8
    } state_t;

    // Accumulator-overwriting (LDA-class) functions: MSB set, low five bits clear.
    function automatic logic is_lda(input logic [5:0] func);
        return func[5] && (func[4:0] == 5'd0);
    endfunction

endpackage

// File: rtl/control_sequencer_beat_generator.sv
// Eight-beat phase counter with halt/run gating; emits the read/write phase
// strobes, the scan flag and the current beat.
module control_sequencer_beat_generator
    import control_sequencer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   hold,
    input  logic   stop,
    input  logic   resume,
    output state_t phase,
    output logic   halted,
    output logic   active,
    output logic   ready_out,
    output logic   ready_in,
    output logic   hs
);

    state_t state, state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S1_OUT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HALT:    if (resume) state_next = S1_OUT;
            S1_OUT:  if (!hold) state_next = S1_IN;
            A2_IN:   state_next = stop ? HALT : S1_OUT;
            default: state_next = state_t'(state + 4'd1);
        endcase
    end

    // Sitting at the instruction boundary without permission to go counts as halted.
    assign halted    = (state == HALT) || (state == S1_OUT && hold);
    assign active    = rst_n && !halted;
    assign phase     = state;
    assign ready_out = active && !state[0];
    assign ready_in  = active &&  state[0];
    assign hs        = active && !state[1];

endmodule

// File: rtl/control_sequencer.sv
// Control sequencer: holds CI/PI, sequences fetch/decode/execute over eight
// beats and drives store address, function code and accumulator enables.
// Optional build macro SINGLE_STEP_EN adds w_STEP single-instruction stepping.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int LINE_LENGTH         = 40,
    parameter int INSTR_ADDR_BITS     = FUNC_LSB - ADDR_LSB,
    parameter int INSTR_FUNCTION_BITS = 6
) (
    input  logic                           w_CLK,
    input  logic                           w_RST_N,
    input  logic                           w_RUN,
`ifdef SINGLE_STEP_EN
    input  logic                           w_STEP,
`endif
    input  logic [LINE_LENGTH-1:0]         b_MS_DATA_OUT,
    input  logic                           w_A_NEG,
    output logic                           ready_out,
    output logic                           ready_in,
    output logic                           w_HS,
    output logic                           w_ACTION,
    output logic                           w_A_ZERO,
    output logic [INSTR_ADDR_BITS-1:0]     b_MS_ADDR,
    output logic [INSTR_FUNCTION_BITS-1:0] b_FST_OUT,
    output logic                           w_STA,
    output logic                           w_HALTED
);

    localparam int PI_W = INSTR_ADDR_BITS + INSTR_FUNCTION_BITS;

    logic [INSTR_ADDR_BITS-1:0]     ci;
    logic [PI_W-1:0]                pi;
    logic [INSTR_ADDR_BITS-1:0]     pi_addr;
    logic [INSTR_FUNCTION_BITS-1:0] pi_func;
    state_t phase;
    logic   active, run_q, armed, a_neg_q;
    logic   hold, stop, resume, run_rise, in_a2, is_a2;
    logic   op_cmp, op_jmp, op_sta, op_hlt;
    logic   unused_data;

    assign pi_addr = pi[ADDR_LSB +: INSTR_ADDR_BITS];
    assign pi_func = pi[FUNC_LSB +: INSTR_FUNCTION_BITS];
    assign op_cmp  = (pi_func == INST_CMP);
    assign op_jmp  = (pi_func == INST_JMP);
    assign op_sta  = (pi_func == INST_STA);
    assign op_hlt  = (pi_func == INST_HLT);

    assign run_rise = w_RUN && !run_q;
    // A resume arms exactly one pass through S1_OUT even if w_RUN is low.
    assign hold     = !w_RUN && !armed;

`ifdef SINGLE_STEP_EN
    logic hlt_halt;

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N)                         hlt_halt <= 1'b0;
        else if (!w_HALTED && phase == A2_IN) hlt_halt <= op_hlt;
        else if (w_HALTED && resume)          hlt_halt <= 1'b0;
    end

    assign stop   = 1'b1;
    assign resume = run_rise || (w_STEP && !hlt_halt);
`else
    assign stop   = !w_RUN || op_hlt;
    assign resume = run_rise;
`endif

    control_sequencer_beat_generator u_beat_generator (
        .clk       (w_CLK),
        .rst_n     (w_RST_N),
        .hold      (hold),
        .stop      (stop),
        .resume    (resume),
        .phase     (phase),
        .halted    (w_HALTED),
        .active    (active),
        .ready_out (ready_out),
        .ready_in  (ready_in),
        .hs        (w_HS)
    );

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            ci      <= '0;
            pi      <= '0;
            run_q   <= 1'b0;
            armed   <= 1'b0;
            a_neg_q <= 1'b0;
        end else begin
            run_q <= w_RUN;
            if (w_HALTED && resume)   armed <= 1'b1;
            else if (phase == S1_OUT) armed <= 1'b0;
            if (!w_HALTED) begin
                case (phase)
                    S1_IN:  ci <= ci + INSTR_ADDR_BITS'(1);
                    A1_IN:  pi <= b_MS_DATA_OUT[PI_W-1:0];
                    A2_OUT: a_neg_q <= w_A_NEG;
                    A2_IN: begin
                        // Store data here is the word at the operand address.
                        if (op_jmp)
                            ci <= b_MS_DATA_OUT[ADDR_LSB +: INSTR_ADDR_BITS];
                        else if (op_cmp && a_neg_q)
                            ci <= ci + INSTR_ADDR_BITS'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_a2     = (phase == A2_OUT) || (phase == A2_IN);
    assign is_a2     = active && in_a2;
    assign w_ACTION  = is_a2;
    assign w_A_ZERO  = is_a2 && is_lda(pi_func);
    assign w_STA     = is_a2 && op_sta;
    assign b_MS_ADDR = is_a2 ? pi_addr : ci;
    assign b_FST_OUT = pi_func;

    assign unused_data = ^b_MS_DATA_OUT[LINE_LENGTH-1:PI_W];

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: an instruction-level model of CI
// and the store predicts every beat's strobes, addresses and decode outputs.
module tb_control_sequencer;

    localparam logic [5:0] OP_CMP = 6'b000101;
    localparam logic [5:0] OP_JMP = 6'b001101;
    localparam logic [5:0] OP_STA = 6'b010100;
    localparam logic [5:0] OP_HLT = 6'b111111;
    localparam logic [5:0] OP_LDA = 6'b100000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        a_neg = 1'b0;
    logic [39:0] ms_data = '0;
    logic        ro, ri, hs, act, az, sta, halted;
    logic [9:0]  ms_addr;
    logic [5:0]  fst;

    logic [39:0] mem [0:1023];
    int          ref_ci;
    int          n_checks = 0;
    int          n_errors = 0;

    control_sequencer dut (
        .w_CLK         (clk),
        .w_RST_N       (rst_n),
        .w_RUN         (run),
        .b_MS_DATA_OUT (ms_data),
        .w_A_NEG       (a_neg),
        .ready_out     (ro),
        .ready_in      (ri),
        .w_HS          (hs),
        .w_ACTION      (act),
        .w_A_ZERO      (az),
        .b_MS_ADDR     (ms_addr),
        .b_FST_OUT     (fst),
        .w_STA         (sta),
        .w_HALTED      (halted)
    );

    always #5 clk = ~clk;

    // Main store with a registered read port.
    always @(posedge clk) ms_data <= mem[ms_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] word(input logic [5:0] op, input logic [9:0] addr);
        logic [23:0] junk;
        junk = 24'($urandom);
        return {junk, op, addr};
    endfunction

    task automatic wait_s1();
        int n = 0;
        while (!(ro && hs) && n < 12) begin
            @(negedge clk); #1;
            n++;
        end
        chk("resume_s1", {ro, hs, halted}, 3'b110);
    endtask

    task automatic do_reset(input bit run_during);
        @(negedge clk); #1;
        rst_n = 1'b0;
        run   = run_during;
        #1;
        chk("reset_outputs", {ro, ri, hs, act, az, sta, ms_addr, fst}, '0);
        chk("reset_halted", halted, !run_during);
        run = 1'b1;
        #1;
        chk("reset_halted_run", halted, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n  = 1'b1;
        #1;
        ref_ci = 0;
        wait_s1();
    endtask

    // One instruction, starting in its first scan beat. neg is the accumulator
    // sign for this instruction; drop_run lowers w_RUN part-way through.
    task automatic run_instr(input bit neg, input bit drop_run);
        logic [9:0]  fetch, addr, nxt;
        logic [39:0] w;
        logic [5:0]  func;
        logic [6:0]  exp_v;
        bit          lda_c, sta_c, stops;
        fetch = 10'((ref_ci + 1) % 1024);
        w     = mem[fetch];
        func  = w[15:10];
        addr  = w[9:0];
        lda_c = (func == OP_LDA);
        sta_c = (func == OP_STA);
        a_neg = neg;
        for (int k = 0; k < 8; k++) begin
            exp_v = {k % 2 == 0, k % 2 == 1, (k / 2) % 2 == 0, k >= 6,
                     k >= 6 && lda_c, k >= 6 && sta_c, 1'b0};
            chk("beat_strobes", {ro, ri, hs, act, az, sta, halted}, exp_v);
            if (k == 2) chk("fetch_addr", ms_addr, fetch);
            if (k == 4) chk("function_code", fst, func);
            if (k == 6) chk("operand_addr", ms_addr, addr);
            if (drop_run && k == 3) run = 1'b0;
            @(negedge clk); #1;
        end
        if (func == OP_CMP && neg)  nxt = fetch + 10'd1;
        else if (func == OP_JMP)    nxt = mem[addr][9:0];
        else                        nxt = fetch;
        ref_ci = int'(nxt);
        stops  = (func == OP_HLT) || drop_run;
        if (stops) begin
            chk("halted_entry", {ro, ri, hs, act, halted}, 5'b00001);
            for (int c = 0; c < ((func == OP_HLT) ? 20 : 3); c++) begin
                @(negedge clk); #1;
                chk("halted_hold", {ro, ri, hs, act, sta, halted}, 6'b000001);
            end
            run = 1'b0;
            @(negedge clk); #1;
            run = 1'b1;
            wait_s1();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // LDA-class fetch from address 1, then a pass-through word at 2.
        mem[1] = word(OP_LDA, 10'd7);
        do_reset(1'b0);
        run_instr(1'b0, 1'b0);
        run_instr(1'b0, 1'b0);

        // CMP skip taken / not taken.
        mem[1] = word(OP_CMP, 10'd40);
        do_reset(1'b1);
        run_instr(1'b1, 1'b0);
        chk("cmp_skip_ci", ref_ci, 2);
        run_instr(1'b0, 1'b0);
        do_reset(1'b1);
        run_instr(1'b0, 1'b0);
        run_instr(1'b0, 1'b0);

        // Indirect jump: store[5]=9 so the next fetch is from 10.
        mem[1] = word(OP_JMP, 10'd5);
        mem[5] = word(6'd0, 10'd9);
        do_reset(1'b1);
        run_instr(1'b0, 1'b0);
        chk("jmp_target", ref_ci, 9);
        run_instr(1'b0, 1'b0);

        // CMP skip at 1023 wraps so the following fetch is from 1.
        mem[5]    = word(6'd0, 10'd1022);
        mem[1023] = word(OP_CMP, 10'd3);
        do_reset(1'b1);
        run_instr(1'b0, 1'b0);
        run_instr(1'b1, 1'b0);
        chk("wrap_ci", ref_ci, 0);
        run_instr(1'b0, 1'b0);

        // HLT at 1, then resume via a w_RUN toggle fetching from 2.
        mem[1] = word(OP_HLT, 10'd0);
        mem[2] = word(6'd0, 10'd0);
        do_reset(1'b1);
        run_instr(1'b0, 1'b0);
        run_instr(1'b0, 1'b0);

        // Reset during A2_OUT of STA drops the write qualifier at once.
        mem[1] = word(OP_STA, 10'd33);
        do_reset(1'b1);
        repeat (6) begin @(negedge clk); #1; end
        chk("sta_before_reset", {sta, ro, act}, 3'b111);
        rst_n = 1'b0;
        #1;
        chk("sta_reset_drop", {sta, ro, ri, act}, 4'b0000);
        @(negedge clk);
        rst_n  = 1'b1;
        #1;
        ref_ci = 0;
        wait_s1();
        run_instr(1'b0, 1'b0);

        // Random program with random accumulator signs and w_RUN drops.
        for (int i = 0; i < 1024; i++) begin
            case ($urandom_range(0, 15))
                0, 1, 2: mem[i] = word(OP_CMP, 10'($urandom));
                3, 4:    mem[i] = word(OP_JMP, 10'($urandom));
                5, 6:    mem[i] = word(OP_STA, 10'($urandom));
                7, 8:    mem[i] = word(OP_LDA, 10'($urandom));
                9:       mem[i] = word(OP_HLT, 10'($urandom));
                default: mem[i] = word(6'($urandom), 10'($urandom));
            endcase
        end
        do_reset(1'b1);
        for (int n = 0; n < 80; n++)
            run_instr(1'($urandom), ($urandom_range(0, 9) == 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
